// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package ctrl_pkg;

    typedef enum logic [4:0] {
        StIdle, StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAdr, StMemRd, StMemWb,
        StMemWr, StBranch, StJal, StJalr, StJalr2, StLui, StAuipc, StTrap
    } state_t;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_ctrl_t;

    // Operation class requested by the FSM; AluOpFunct defers to funct3/funct7.
    typedef enum logic [1:0] {AluOpAdd, AluOpSub, AluOpFunct} alu_op_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;
    localparam logic [1:0] SRC_B_IMM_U  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_RESET   = 2'b11;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's operation class and instruction fields to an ALU code.
module alu_dec
    import ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [6:0] opcode,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = AluAdd;
        case (alu_op)
            AluOpSub: alu_ctrl = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // funct7_5 selects SUB only for register-register ops; ADDI ignores it.
                    3'b000: alu_ctrl = (opcode == OP_R_TYPE && funct7_5) ? AluSub : AluAdd;
                    3'b001: alu_ctrl = AluSll;
                    3'b010: alu_ctrl = AluSlt;
                    3'b011: alu_ctrl = AluSltu;
                    3'b100: alu_ctrl = AluXor;
                    3'b101: alu_ctrl = funct7_5 ? AluSra : AluSrl;
                    3'b110: alu_ctrl = AluOr;
                    3'b111: alu_ctrl = AluAnd;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit RESET_VECTOR_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       en,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       illegal
);

    state_t  state_q, state_d;
    logic    fetch_busy_q, fetch_busy_d;
    logic    illegal_q;
    alu_op_t alu_op;

    alu_dec u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .opcode   (opcode),
        .alu_ctrl (alu_ctrl)
    );

    always_comb begin
        state_d      = state_q;
        fetch_busy_d = 1'b0;
        alu_op       = AluOpAdd;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_ALU;
        reg_we       = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        result_src   = RES_ALU_OUT;
        retire       = 1'b0;

        case (state_q)
            StIdle: begin
                // RESET gating keeps the vector load quiet while reset is still held.
                if (en && !RESET) begin
                    state_d = StFetch;
                    if (RESET_VECTOR_EN) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_RESET;
                    end
                end
            end
            StFetch: begin
                // en is only sampled before the request goes out; an open request must finish.
                if (!en && !fetch_busy_q) begin
                    state_d = StIdle;
                end else begin
                    mem_req   = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    pc_src    = PC_SRC_ALU;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StDecode;
                    end else begin
                        fetch_busy_d = 1'b1;
                    end
                end
            end
            StDecode: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R_TYPE:         state_d = StExecR;
                    OP_I_TYPE:         state_d = StExecI;
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    OP_JALR:           state_d = StJalr;
                    OP_LUI:            state_d = StLui;
                    OP_AUIPC:          state_d = StAuipc;
                    default:           state_d = StTrap;
                endcase
            end
            StExecR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_we     = 1'b1;
                result_src = RES_ALU_OUT;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemAdr: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_we     = 1'b1;
                result_src = RES_MEM;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StBranch: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = AluOpSub;
                if (funct3[2:1] == 2'b01) begin
                    state_d = StTrap;
                end else begin
                    pc_we   = branch_taken(funct3, zero, lt, ltu);
                    pc_src  = PC_SRC_ALU_OUT;
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StJal, StJalr2: begin
                // ALUOut holds the jump target; the ALU forms the link value oldPC+4.
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                pc_src     = PC_SRC_ALU_OUT;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = StJalr2;
            end
            StLui: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM_U;
                state_d   = StAluWb;
            end
            StAuipc: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM_U;
                state_d   = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            fetch_busy_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_busy_q <= fetch_busy_d;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction cycle model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        logic [1:0] res;
        logic       retire;
        logic       illegal;
    } outs_t;

    logic       CLK = 1'b0;
    logic       RESET, en, funct7_5, zero, lt, ltu, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, retire, illegal;
    logic [1:0] pc_src, alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_ctrl;

    int checks = 0;
    int errors = 0;

    outs_t      exp_q[$];
    logic       rdy_q[$];
    logic [31:0] cur_ir;
    logic       cur_z, cur_l, cur_lu, cur_rdy, cur_en;
    logic [6:0] ops [9];
    logic [2:0] br_f3 [6];

    multicycle_ctrl dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .en         (en),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic outs_t sample();
        outs_t o;
        o.mem_req = mem_req;   o.mem_we = mem_we;     o.adr_src = adr_src;
        o.ir_we   = ir_we;     o.pc_we  = pc_we;      o.pc_src  = pc_src;
        o.reg_we  = reg_we;    o.a      = alu_src_a;  o.b       = alu_src_b;
        o.alu     = alu_ctrl;  o.res    = result_src; o.retire  = retire;
        o.illegal = illegal;
        return o;
    endfunction

    // Apply the current stimulus in the low phase and sample the settled outputs.
    task automatic step(output outs_t got);
        @(negedge CLK);
        opcode    = cur_ir[6:0];
        funct3    = cur_ir[14:12];
        funct7_5  = cur_ir[30];
        zero      = cur_z;
        lt        = cur_l;
        ltu       = cur_lu;
        mem_ready = cur_rdy;
        en        = cur_en;
        #1;
        got = sample();
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] alu_rule(input logic is_r, input logic [2:0] f3,
                                            input logic f7);
        case (f3)
            3'd0: return (is_r && f7) ? AluSub : AluAdd;
            3'd1: return AluSll;
            3'd2: return AluSlt;
            3'd3: return AluSltu;
            3'd4: return AluXor;
            3'd5: return f7 ? AluSra : AluSrl;
            3'd6: return AluOr;
            default: return AluAnd;
        endcase
    endfunction

    function automatic logic taken_rule(input logic [2:0] f3, input logic z, input logic l,
                                        input logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            default: return !lu;
        endcase
    endfunction

    function automatic void push(input outs_t o, input logic r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endfunction

    function automatic outs_t idle_exit();
        outs_t o = '0;
        o.pc_we  = 1'b1;
        o.pc_src = 2'b11;
        return o;
    endfunction

    // Expected outputs and mem_ready for every cycle of one instruction, from first FETCH cycle.
    function automatic void model(input logic [31:0] ir, input int wf, input int wd);
        outs_t o;
        outs_t wb;
        logic [2:0] f3 = ir[14:12];
        logic f7 = ir[30];
        exp_q.delete();
        rdy_q.delete();
        wb = '0; wb.reg_we = 1'b1; wb.retire = 1'b1;
        for (int i = 0; i < wf; i++) begin
            o = '0; o.mem_req = 1'b1; o.b = 2'b10; push(o, 1'b0);
        end
        o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; o.b = 2'b10; push(o, 1'b1);
        o = '0; o.a = 2'b01; o.b = 2'b01; push(o, rnd_bit());
        case (ir[6:0])
            7'b0110011: begin
                o = '0; o.a = 2'b10; o.alu = alu_rule(1'b1, f3, f7); push(o, rnd_bit());
                push(wb, rnd_bit());
            end
            7'b0010011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.alu = alu_rule(1'b0, f3, f7);
                push(o, rnd_bit());
                push(wb, rnd_bit());
            end
            7'b0000011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; push(o, rnd_bit());
                o = '0; o.mem_req = 1'b1; o.adr_src = 1'b1;
                for (int i = 0; i < wd; i++) push(o, 1'b0);
                push(o, 1'b1);
                o = '0; o.reg_we = 1'b1; o.res = 2'b01; o.retire = 1'b1; push(o, rnd_bit());
            end
            7'b0100011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; push(o, rnd_bit());
                o = '0; o.mem_req = 1'b1; o.mem_we = 1'b1; o.adr_src = 1'b1;
                for (int i = 0; i < wd; i++) push(o, 1'b0);
                o.retire = 1'b1; push(o, 1'b1);
            end
            7'b1100011: begin
                o = '0; o.a = 2'b10; o.alu = AluSub;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    push(o, rnd_bit());
                    o = '0; o.illegal = 1'b1; push(o, rnd_bit());
                end else begin
                    o.pc_we = taken_rule(f3, cur_z, cur_l, cur_lu);
                    o.pc_src = 2'b01; o.retire = 1'b1; push(o, rnd_bit());
                end
            end
            7'b1101111, 7'b1100111: begin
                if (ir[6:0] == 7'b1100111) begin
                    o = '0; o.a = 2'b10; o.b = 2'b01; push(o, rnd_bit());
                end
                o = '0; o.a = 2'b01; o.b = 2'b10; o.res = 2'b10; o.reg_we = 1'b1;
                o.pc_we = 1'b1; o.pc_src = 2'b01; o.retire = 1'b1; push(o, rnd_bit());
            end
            7'b0110111: begin
                o = '0; o.a = 2'b11; o.b = 2'b11; push(o, rnd_bit()); push(wb, rnd_bit());
            end
            7'b0010111: begin
                o = '0; o.a = 2'b01; o.b = 2'b11; push(o, rnd_bit()); push(wb, rnd_bit());
            end
            default: begin
                o = '0; o.illegal = 1'b1; push(o, rnd_bit());
            end
        endcase
    endfunction

    task automatic test_reset();
        outs_t got;
        RESET = 1'b1; cur_en = 1'b1; cur_rdy = 1'b1; cur_ir = '0;
        cur_z = 1'b0; cur_l = 1'b0; cur_lu = 1'b0;
        step(got);
        checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL reset_outputs: got %h required %h", got, outs_t'('0));
        end
        RESET = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== idle_exit()) begin
            errors++; $display("FAIL idle_exit: got %h required %h", got, idle_exit());
        end
    endtask

    task automatic test_add();
        outs_t got;
        cur_ir = 32'h002081B3;
        model(cur_ir, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_rdy = 1'b1; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL add cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_fetch_wait();
        outs_t got;
        cur_ir = 32'h002081B3;
        model(cur_ir, 3, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL fetch_wait cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        outs_t got;
        for (int k = 0; k < 2; k++) begin
            cur_ir = 32'h00208463; cur_z = (k == 0);
            model(cur_ir, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                cur_rdy = rdy_q[i]; step(got); checks++;
                if (got !== exp_q[i]) begin
                    errors++;
                    $display("FAIL beq z=%0d cyc%0d: got %h required %h", cur_z, i, got, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_store_wait();
        outs_t got;
        cur_ir = 32'h0020A223;
        model(cur_ir, 0, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL sw_wait cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        outs_t got;
        int k;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 8);
            cur_ir = $urandom;
            cur_ir[6:0] = ops[k];
            if (ops[k] == 7'b1100011) cur_ir[14:12] = br_f3[$urandom_range(0, 5)];
            cur_z = rnd_bit(); cur_l = rnd_bit(); cur_lu = rnd_bit();
            model(cur_ir, $urandom_range(0, 2), $urandom_range(0, 2));
            for (int i = 0; i < exp_q.size(); i++) begin
                cur_rdy = rdy_q[i]; step(got); checks++;
                if (got !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand ir=%h cyc%0d: got %h required %h",
                             cur_ir, i, got, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_en_stop();
        outs_t got;
        cur_en = 1'b0; step(got); checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL en_abort: got %h required %h", got, outs_t'('0));
        end
        cur_en = 1'b1; step(got); checks++;
        if (got !== idle_exit()) begin
            errors++; $display("FAIL en_restart: got %h required %h", got, idle_exit());
        end
        // en drops after the fetch request is out: fetch and instruction still complete.
        cur_ir = 32'h40208033;
        model(cur_ir, 2, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_en = (i == 0); cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL en_hold cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        step(got); checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL en_stop: got %h required %h", got, outs_t'('0));
        end
        cur_en = 1'b1; step(got); checks++;
        if (got !== idle_exit()) begin
            errors++; $display("FAIL en_resume: got %h required %h", got, idle_exit());
        end
    endtask

    task automatic test_trap();
        outs_t got;
        outs_t t = '0;
        t.illegal = 1'b1;
        cur_ir = 32'h0000007F;
        model(cur_ir, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL trap_entry cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            cur_en = rnd_bit(); cur_rdy = rnd_bit(); step(got); checks++;
            if (got !== t) begin
                errors++; $display("FAIL trap_hold cyc%0d: got %h required %h", i, got, t);
            end
        end
        cur_en = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        outs_t got;
        RESET = 1'b1; #1; got = sample(); checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL reset_clears_trap: got %h required %h", got, outs_t'('0));
        end
        step(got); RESET = 1'b0; #1; got = sample(); checks++;
        if (got !== idle_exit()) begin
            errors++; $display("FAIL reset_exit1: got %h required %h", got, idle_exit());
        end
        cur_ir = 32'h0020A223;
        model(cur_ir, 0, 3);
        for (int i = 0; i < 4; i++) begin
            cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL sw_pre_reset cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
        RESET = 1'b1; #1; got = sample(); checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL reset_mid_write: got %h required %h", got, outs_t'('0));
        end
        cur_rdy = 1'b1; step(got); checks++;
        if (got !== outs_t'('0)) begin
            errors++; $display("FAIL reset_held: got %h required %h", got, outs_t'('0));
        end
        RESET = 1'b0; #1; got = sample(); checks++;
        if (got !== idle_exit()) begin
            errors++; $display("FAIL reset_exit2: got %h required %h", got, idle_exit());
        end
    endtask

    task automatic test_branch_trap();
        outs_t got;
        cur_ir = 32'h0020A463;
        model(cur_ir, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            cur_rdy = rdy_q[i]; step(got); checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("FAIL branch_trap cyc%0d: got %h required %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        RESET = 1'b1; en = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_fetch_wait();
        test_branch();
        test_store_wait();
        test_back_to_back();
        test_en_stop();
        test_trap();
        test_reset_mid_write();
        test_branch_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
